// File: rtl/id_ex_issue.sv
// Decode/issue stage: register-file addressing, load-use stall, EX control decode,
// the ID/EX pipeline register and the N/Z/V flag register.
module id_ex_issue #(
    parameter int         DW       = 16,
    parameter logic [2:0] FLAG_RST = 3'b000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_valid,
    input  logic [DW-1:0] if_pc,
    input  logic [DW-1:0] if_instr,
    input  logic          flush,
    output logic          stall,
    output logic [3:0]    rf_addr1,
    output logic [3:0]    rf_addr2,
    input  logic [DW-1:0] rf_data1,
    input  logic [DW-1:0] rf_data2,
    input  logic [2:0]    ex_flags,
    output logic          ex_valid,
    output logic [DW-1:0] pc,
    output logic [DW-1:0] instr,
    output logic [DW-1:0] reg1,
    output logic [DW-1:0] reg2,
    output logic          aluSrc,
    output logic [3:0]    aluOp,
    output logic [3:0]    shAmt,
    output logic [2:0]    flagsIn,
    output logic          ex_memRead,
    output logic          ex_regWrite,
    output logic [3:0]    ex_dst,
    output logic          halted
);

    localparam logic [3:0] OP_ADD = 4'h0, OP_PADDSB = 4'h1, OP_SUB = 4'h2;
    localparam logic [3:0] OP_LW  = 4'h8, OP_SW  = 4'h9, OP_LHB = 4'hA, OP_LLB = 4'hB;
    localparam logic [3:0] OP_JAL = 4'hD, OP_JR  = 4'hE, OP_HLT = 4'hF;

    logic [3:0] op, rd, rs, rt;
    logic       is_alu, use1, use2;
    logic [3:0] dec_dst;
    logic       dec_rw, hazard, issue;

    logic          ex_valid_reg, mem_read_reg, reg_write_reg, alu_src_reg, halted_reg;
    logic [3:0]    dst_reg, alu_op_reg, sh_amt_reg;
    logic [DW-1:0] pc_reg, instr_reg, reg1_reg, reg2_reg;
    logic [2:0]    flag_reg, flag_load;
    logic [3:0]    ex_op;
    logic          load_all, load_z;

    assign op = if_instr[15:12];
    assign rd = if_instr[11:8];
    assign rs = if_instr[7:4];
    assign rt = if_instr[3:0];

    always_comb begin
        is_alu   = ~op[3];
        rf_addr1 = (op == OP_LHB) ? rd : rs;
        rf_addr2 = is_alu ? rt : ((op == OP_SW) ? rd : 4'h0);
        use1     = is_alu | (op == OP_SW) | (op == OP_LW) | (op == OP_JR) | (op == OP_LHB);
        use2     = is_alu | (op == OP_SW);
        dec_dst  = (op == OP_JAL) ? 4'hF : rd;
        // A write to r0 is architecturally a no-op, so it must not trigger forwarding or stalls.
        dec_rw   = (is_alu | (op == OP_LW) | (op == OP_LHB) | (op == OP_LLB) | (op == OP_JAL))
                   & (dec_dst != 4'h0);
        hazard   = ex_valid_reg & mem_read_reg & reg_write_reg & if_valid & ~halted_reg & ~flush
                   & ((use1 & (dst_reg == rf_addr1)) | (use2 & (dst_reg == rf_addr2)));
        stall    = halted_reg | hazard;
        issue    = if_valid & ~flush & ~hazard & ~halted_reg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_reg  <= 1'b0;
            mem_read_reg  <= 1'b0;
            reg_write_reg <= 1'b0;
            alu_src_reg   <= 1'b0;
            halted_reg    <= 1'b0;
            dst_reg       <= '0;
            alu_op_reg    <= '0;
            sh_amt_reg    <= '0;
            pc_reg        <= '0;
            instr_reg     <= '0;
            reg1_reg      <= '0;
            reg2_reg      <= '0;
        end else if (issue) begin
            ex_valid_reg  <= 1'b1;
            mem_read_reg  <= (op == OP_LW);
            reg_write_reg <= dec_rw;
            alu_src_reg   <= is_alu;
            dst_reg       <= dec_dst;
            alu_op_reg    <= op;
            sh_amt_reg    <= rt;
            pc_reg        <= if_pc;
            instr_reg     <= if_instr;
            reg1_reg      <= rf_data1;
            reg2_reg      <= rf_data2;
            if (op == OP_HLT)
                halted_reg <= 1'b1;
        end else begin
            // Bubble: only the fields that can cause side effects are cleared.
            ex_valid_reg  <= 1'b0;
            mem_read_reg  <= 1'b0;
            reg_write_reg <= 1'b0;
            instr_reg     <= '0;
        end
    end

    assign ex_op    = instr_reg[15:12];
    assign load_all = ex_valid_reg & ((ex_op == OP_ADD) | (ex_op == OP_SUB) | (ex_op == OP_PADDSB));
    assign load_z   = ex_valid_reg & (ex_op >= 4'h3) & (ex_op <= 4'h7);

    // Bit order is {N,Z,V}; logic and shift ops only refresh Z.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_flag_load
            if (gi == 1) begin : g_z
                assign flag_load[gi] = load_all | load_z;
            end else begin : g_nv
                assign flag_load[gi] = load_all;
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_reg <= FLAG_RST;
        end else begin
            for (int i = 0; i < 3; i++)
                if (flag_load[i])
                    flag_reg[i] <= ex_flags[i];
        end
    end

    assign ex_valid    = ex_valid_reg;
    assign pc          = pc_reg;
    assign instr       = instr_reg;
    assign reg1        = reg1_reg;
    assign reg2        = reg2_reg;
    assign aluSrc      = alu_src_reg;
    assign aluOp       = alu_op_reg;
    assign shAmt       = sh_amt_reg;
    assign flagsIn     = flag_reg;
    assign ex_memRead  = mem_read_reg;
    assign ex_regWrite = reg_write_reg;
    assign ex_dst      = dst_reg;
    assign halted      = halted_reg;

endmodule

// File: tb/tb_id_ex_issue.sv
// Directed, table-driven bench for id_ex_issue plus hand-written async-reset sequences.
module tb_id_ex_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [15:0] if_pc, if_instr;
    logic        flush;
    logic        stall;
    logic [3:0]  rf_addr1, rf_addr2;
    logic [15:0] rf_data1, rf_data2;
    logic [2:0]  ex_flags;
    logic        ex_valid;
    logic [15:0] pc, instr, reg1, reg2;
    logic        aluSrc;
    logic [3:0]  aluOp, shAmt;
    logic [2:0]  flagsIn;
    logic        ex_memRead, ex_regWrite;
    logic [3:0]  ex_dst;
    logic        halted;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    id_ex_issue #(.DW(16), .FLAG_RST(3'b101)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
        .flush(flush), .stall(stall), .rf_addr1(rf_addr1), .rf_addr2(rf_addr2),
        .rf_data1(rf_data1), .rf_data2(rf_data2), .ex_flags(ex_flags), .ex_valid(ex_valid),
        .pc(pc), .instr(instr), .reg1(reg1), .reg2(reg2), .aluSrc(aluSrc), .aluOp(aluOp),
        .shAmt(shAmt), .flagsIn(flagsIn), .ex_memRead(ex_memRead), .ex_regWrite(ex_regWrite),
        .ex_dst(ex_dst), .halted(halted)
    );

    typedef struct {
        logic        v;
        logic [15:0] ins;
        logic [15:0] d1;
        logic [2:0]  fl;
        logic        fls;
        logic        e_stall;
        logic [3:0]  e_a1;
        logic [3:0]  e_a2;
        logic        e_valid;
        logic        e_rw;
        logic        e_mr;
        logic [3:0]  e_dst;
        logic [2:0]  e_flags;
        logic        e_halt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic v, logic [15:0] ins, logic [15:0] d1, logic [2:0] fl,
                                logic fls, logic s, logic [3:0] a1, logic [3:0] a2,
                                logic ev, logic rw, logic mr, logic [3:0] dst,
                                logic [2:0] ef, logic h);
        vec_t t;
        t.v = v; t.ins = ins; t.d1 = d1; t.fl = fl; t.fls = fls;
        t.e_stall = s; t.e_a1 = a1; t.e_a2 = a2; t.e_valid = ev; t.e_rw = rw;
        t.e_mr = mr; t.e_dst = dst; t.e_flags = ef; t.e_halt = h;
        return t;
    endfunction

    task automatic chk(input string name, input int step, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d got=%h expected=%h", name, step, act, exp);
        end
    endtask

    initial begin
        // flags column: {N,Z,V} after the edge; FLAG_RST=101 until the first full load
        vecs.push_back(mk(1, 16'h0312, 16'h0005, 3'b000, 0, 0, 4'h1, 4'h2, 1, 1, 0, 4'h3, 3'b101, 0));
        vecs.push_back(mk(1, 16'h3612, 16'h0001, 3'b010, 0, 0, 4'h1, 4'h2, 1, 1, 0, 4'h6, 3'b010, 0));
        vecs.push_back(mk(1, 16'h0512, 16'h0003, 3'b101, 0, 0, 4'h1, 4'h2, 1, 1, 0, 4'h5, 3'b000, 0));
        vecs.push_back(mk(1, 16'h3712, 16'h0004, 3'b101, 0, 0, 4'h1, 4'h2, 1, 1, 0, 4'h7, 3'b101, 0));
        vecs.push_back(mk(1, 16'h8412, 16'h0009, 3'b010, 0, 0, 4'h1, 4'h0, 1, 1, 1, 4'h4, 3'b111, 0));
        vecs.push_back(mk(1, 16'h2546, 16'h0011, 3'b000, 0, 1, 4'h4, 4'h6, 0, 0, 0, 4'h0, 3'b111, 0));
        vecs.push_back(mk(1, 16'h2546, 16'h0022, 3'b000, 0, 0, 4'h4, 4'h6, 1, 1, 0, 4'h5, 3'b111, 0));
        vecs.push_back(mk(1, 16'h8412, 16'h0008, 3'b000, 0, 0, 4'h1, 4'h0, 1, 1, 1, 4'h4, 3'b000, 0));
        vecs.push_back(mk(1, 16'hB4AB, 16'h0033, 3'b000, 0, 0, 4'hA, 4'h0, 1, 1, 0, 4'h4, 3'b000, 0));
        vecs.push_back(mk(1, 16'h8412, 16'h0001, 3'b000, 0, 0, 4'h1, 4'h0, 1, 1, 1, 4'h4, 3'b000, 0));
        vecs.push_back(mk(1, 16'h2546, 16'h0000, 3'b000, 1, 0, 4'h4, 4'h6, 0, 0, 0, 4'h0, 3'b000, 0));
        vecs.push_back(mk(1, 16'h2546, 16'h0044, 3'b000, 0, 0, 4'h4, 4'h6, 1, 1, 0, 4'h5, 3'b000, 0));
        vecs.push_back(mk(1, 16'h9721, 16'h0055, 3'b000, 0, 0, 4'h2, 4'h7, 1, 0, 0, 4'h7, 3'b000, 0));
        vecs.push_back(mk(1, 16'h0012, 16'h0066, 3'b111, 0, 0, 4'h1, 4'h2, 1, 0, 0, 4'h0, 3'b000, 0));
        vecs.push_back(mk(1, 16'h8012, 16'h0077, 3'b110, 0, 0, 4'h1, 4'h0, 1, 0, 1, 4'h0, 3'b110, 0));
        vecs.push_back(mk(1, 16'h0300, 16'h0088, 3'b001, 0, 0, 4'h0, 4'h0, 1, 1, 0, 4'h3, 3'b110, 0));
        vecs.push_back(mk(0, 16'h0312, 16'h0099, 3'b001, 0, 0, 4'h1, 4'h2, 0, 0, 0, 4'h0, 3'b001, 0));
        vecs.push_back(mk(1, 16'hD000, 16'h00AA, 3'b111, 0, 0, 4'h0, 4'h0, 1, 1, 0, 4'hF, 3'b001, 0));
        vecs.push_back(mk(1, 16'hF000, 16'h00BB, 3'b111, 0, 0, 4'h0, 4'h0, 1, 0, 0, 4'h0, 3'b001, 1));
        vecs.push_back(mk(1, 16'h0312, 16'h00CC, 3'b111, 0, 1, 4'h1, 4'h2, 0, 0, 0, 4'h0, 3'b001, 1));
        vecs.push_back(mk(1, 16'h0312, 16'h00DD, 3'b111, 0, 1, 4'h1, 4'h2, 0, 0, 0, 4'h0, 3'b001, 1));

        rst = 1'b1; if_valid = 1'b0; if_pc = '0; if_instr = '0; flush = 1'b0;
        rf_data1 = '0; rf_data2 = '0; ex_flags = '0;
        repeat (2) @(negedge clk);
        chk("rst_ex_valid", -1, {15'd0, ex_valid}, 16'd0);
        chk("rst_flags", -1, {13'd0, flagsIn}, 16'h0005);
        chk("rst_halted", -1, {15'd0, halted}, 16'd0);
        chk("rst_instr", -1, instr, 16'h0000);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t t;
            t = vecs[i];
            if (i != 0) @(negedge clk);
            if_valid = t.v; if_instr = t.ins; if_pc = 16'h0100 + 16'(i);
            rf_data1 = t.d1; rf_data2 = ~t.d1; ex_flags = t.fl; flush = t.fls;
            #1;
            chk("stall", i, {15'd0, stall}, {15'd0, t.e_stall});
            chk("rf_addr1", i, {12'd0, rf_addr1}, {12'd0, t.e_a1});
            chk("rf_addr2", i, {12'd0, rf_addr2}, {12'd0, t.e_a2});
            @(posedge clk); #1;
            chk("ex_valid", i, {15'd0, ex_valid}, {15'd0, t.e_valid});
            chk("ex_regWrite", i, {15'd0, ex_regWrite}, {15'd0, t.e_rw});
            chk("ex_memRead", i, {15'd0, ex_memRead}, {15'd0, t.e_mr});
            chk("flagsIn", i, {13'd0, flagsIn}, {13'd0, t.e_flags});
            chk("halted", i, {15'd0, halted}, {15'd0, t.e_halt});
            chk("instr", i, instr, t.e_valid ? t.ins : 16'h0000);
            if (t.e_valid) begin
                chk("ex_dst", i, {12'd0, ex_dst}, {12'd0, t.e_dst});
                chk("reg1", i, reg1, t.d1);
                chk("reg2", i, reg2, ~t.d1);
                chk("pc", i, pc, 16'h0100 + 16'(i));
                chk("aluOp", i, {12'd0, aluOp}, {12'd0, t.ins[15:12]});
                chk("aluSrc", i, {15'd0, aluSrc}, {15'd0, ~t.ins[15]});
                chk("shAmt", i, {12'd0, shAmt}, {12'd0, t.ins[3:0]});
            end
            $display("vec %0d instr=%h stall=%b ex_valid=%b dst=%h flags=%b halted=%b",
                     i, t.ins, stall, ex_valid, ex_dst, flagsIn, halted);
        end

        // Async reset between edges clears halted without waiting for a clock.
        @(negedge clk);
        if_valid = 1'b1; if_instr = 16'h0312; flush = 1'b0; ex_flags = 3'b000;
        #2 rst = 1'b1;
        #1;
        chk("arst_halted", 100, {15'd0, halted}, 16'd0);
        chk("arst_ex_valid", 100, {15'd0, ex_valid}, 16'd0);
        chk("arst_flags", 100, {13'd0, flagsIn}, 16'h0005);
        chk("arst_stall", 100, {15'd0, stall}, 16'd0);
        $display("seq arst_halt halted=%b stall=%b flags=%b", halted, stall, flagsIn);

        // Reset during a load-use stall, then the held instruction issues cleanly.
        @(negedge clk);
        rst = 1'b0; if_instr = 16'h8412; rf_data1 = 16'h1234;
        @(posedge clk); #1;
        chk("seq_lw_memRead", 101, {15'd0, ex_memRead}, 16'd1);
        @(negedge clk);
        if_instr = 16'h2546; rf_data1 = 16'h5678;
        #1;
        chk("seq_stall_pending", 101, {15'd0, stall}, 16'd1);
        #2 rst = 1'b1;
        #1;
        chk("seq_rst_stall", 101, {15'd0, stall}, 16'd0);
        chk("seq_rst_ex_valid", 101, {15'd0, ex_valid}, 16'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("seq_after_rst_valid", 101, {15'd0, ex_valid}, 16'd1);
        chk("seq_after_rst_instr", 101, instr, 16'h2546);
        chk("seq_after_rst_reg1", 101, reg1, 16'h5678);
        $display("seq rst_mid_stall ex_valid=%b instr=%h reg1=%h", ex_valid, instr, reg1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
